// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard over the shared
// open-drain clock/data pair. The frame is: inhibit (clock held low), request-to-send (data
// low), then the device clocks out 8 data bits LSB first, odd parity and stop, and finally
// answers with an ACK bit.
//
// Ports
//   main_clk            in   system clock
//   rst_n               in   synchronous active-low reset
//   tx_byte[7:0]        in   byte to send, captured on accept
//   tx_valid            in   transfer request, accepted when tx_valid & tx_ready
//   tx_ready            out  high only while idle
//   tx_active           out  high whenever a frame is in progress
//   tx_done             out  one-cycle pulse ending every accepted transfer
//   tx_ack_ok           out  device ACK seen low (held until the next tx_done)
//   tx_error            out  timeout or missing ACK (held until the next tx_done)
//   ps2_clock_pulldown  out  1 = drive PS/2 clock low
//   ps2_data_pulldown   out  1 = drive PS/2 data low
//   ps2_clock_in        in   raw PS/2 clock pin (asynchronous)
//   ps2_data_in         in   raw PS/2 data pin (asynchronous)
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES     = 8334,
    parameter int unsigned FIRST_EDGE_TIMEOUT = 1250000,
    parameter int unsigned EDGE_TIMEOUT       = 166667,
    parameter int unsigned CNT_W              = 21
) (
    input  logic       main_clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error,
    output logic       ps2_clock_pulldown,
    output logic       ps2_data_pulldown,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in
);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StAck,
        StWaitIdle
    } state_e;

    localparam logic [CNT_W-1:0] InhibitLoad = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FirstLoad   = CNT_W'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] EdgeLoad    = CNT_W'(EDGE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             ack_seen_q, ack_seen_d;
    logic             ready_q, ready_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             ack_ok_q, ack_ok_d;
    logic             error_q, error_d;
    logic             clk_pd_q, clk_pd_d;
    logic             dat_pd_q, dat_pd_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;

    logic fall;
    logic cnt_zero;
    logic abort;

    assign fall     = clk_prev_q & ~clk_sync_q;
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        ack_seen_d = ack_seen_q;
        done_d     = 1'b0;
        ack_ok_d   = ack_ok_q;
        error_d    = error_q;
        clk_pd_d   = clk_pd_q;
        dat_pd_d   = dat_pd_q;
        abort      = 1'b0;

        case (state_q)
            StIdle: begin
                clk_pd_d = 1'b0;
                dat_pd_d = 1'b0;
                if (tx_valid) begin
                    shift_d   = {1'b1, ~^tx_byte, tx_byte};
                    bit_cnt_d = 4'd0;
                    cnt_d     = InhibitLoad;
                    clk_pd_d  = 1'b1;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_zero) begin
                    dat_pd_d = 1'b1;  // start bit doubles as request-to-send
                    state_d  = StReq;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StReq: begin
                clk_pd_d = 1'b0;
                cnt_d    = FirstLoad;
                state_d  = StSend;
            end
            StSend: begin
                // A fall takes priority over an expiring watchdog in the same cycle.
                if (fall) begin
                    dat_pd_d  = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    cnt_d     = EdgeLoad;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end
                end else if (cnt_zero) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StAck: begin
                dat_pd_d = 1'b0;
                if (fall) begin
                    ack_seen_d = ~dat_sync_q;
                    cnt_d      = EdgeLoad;
                    state_d    = StWaitIdle;
                end else if (cnt_zero) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StWaitIdle: begin
                if (clk_sync_q && dat_sync_q) begin
                    done_d   = 1'b1;
                    ack_ok_d = ack_seen_q;
                    error_d  = ~ack_seen_q;
                    state_d  = StIdle;
                end else if (cnt_zero) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                clk_pd_d = 1'b0;
                dat_pd_d = 1'b0;
                state_d  = StIdle;
            end
        endcase

        if (abort) begin
            clk_pd_d = 1'b0;
            dat_pd_d = 1'b0;
            done_d   = 1'b1;
            ack_ok_d = 1'b0;
            error_d  = 1'b1;
            state_d  = StIdle;
        end

        // Status outputs are registered from the next state so they line up with it.
        ready_d  = (state_d == StIdle);
        active_d = ~ready_d;
    end

    always_ff @(posedge main_clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            ack_seen_q <= 1'b0;
            ready_q    <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            error_q    <= 1'b0;
            clk_pd_q   <= 1'b0;
            dat_pd_q   <= 1'b0;
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            ack_seen_q <= ack_seen_d;
            ready_q    <= ready_d;
            active_q   <= active_d;
            done_q     <= done_d;
            ack_ok_q   <= ack_ok_d;
            error_q    <= error_d;
            clk_pd_q   <= clk_pd_d;
            dat_pd_q   <= dat_pd_d;
            clk_meta_q <= ps2_clock_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_data_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign tx_ready           = ready_q;
    assign tx_active          = active_q;
    assign tx_done            = done_q;
    assign tx_ack_ok          = ack_ok_q;
    assign tx_error           = error_q;
    assign ps2_clock_pulldown = clk_pd_q;
    assign ps2_data_pulldown  = dat_pd_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with short timing parameters and a simple PS/2 device model
// clocking at a 40-cycle period. The bus is modelled as wired-AND of device and host drivers.
module tb_ps2_host_tx;

    logic       main_clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_active;
    logic       tx_done;
    logic       tx_ack_ok;
    logic       tx_error;
    logic       ps2_clock_pulldown;
    logic       ps2_data_pulldown;
    logic       ps2_clock_in;
    logic       ps2_data_in;
    logic       dev_clk;
    logic       dev_data;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_starts = 0;
    bit         mon_en = 1'b0;
    logic       cpd_prev = 1'b0;

    always #5 main_clk = ~main_clk;

    assign ps2_clock_in = dev_clk & ~ps2_clock_pulldown;
    assign ps2_data_in  = dev_data & ~ps2_data_pulldown;

    ps2_host_tx #(
        .INHIBIT_CYCLES    (10),
        .FIRST_EDGE_TIMEOUT(200),
        .EDGE_TIMEOUT      (50),
        .CNT_W             (21)
    ) dut (
        .main_clk          (main_clk),
        .rst_n             (rst_n),
        .tx_byte           (tx_byte),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .tx_active         (tx_active),
        .tx_done           (tx_done),
        .tx_ack_ok         (tx_ack_ok),
        .tx_error          (tx_error),
        .ps2_clock_pulldown(ps2_clock_pulldown),
        .ps2_data_pulldown (ps2_data_pulldown),
        .ps2_clock_in      (ps2_clock_in),
        .ps2_data_in       (ps2_data_in)
    );

    // Counts host frame starts (clock pulldown rising) while enabled.
    always @(negedge main_clk) begin
        if (mon_en && ps2_clock_pulldown && !cpd_prev) n_starts++;
        cpd_prev = ps2_clock_pulldown;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge main_clk);
    endtask

    // Request a byte and follow the host through inhibit and request-to-send.
    task automatic start_tx(input logic [7:0] b, input bit hold);
        int n;
        tx_byte  = b;
        tx_valid = 1'b1;
        tick();
        if (!hold) tx_valid = 1'b0;
        check("accept_ready_low", 32'(tx_ready), 0);
        check("accept_active", 32'(tx_active), 1);
        n = 0;
        while (ps2_clock_pulldown && !ps2_data_pulldown && n < 100) begin
            n++;
            tick();
        end
        check("inhibit_cycles", n, 10);
        check("req_clock_low", 32'(ps2_clock_pulldown), 1);
        check("req_data_low", 32'(ps2_data_pulldown), 1);
        tick();
        check("send_clock_released", 32'(ps2_clock_pulldown), 0);
        check("send_start_bit", 32'(ps2_data_pulldown), 1);
    endtask

    // Device clocks nfalls cycles, sampling the bus on each rising edge.
    task automatic dev_bits(input int nfalls, output logic [9:0] bits);
        bits = '0;
        repeat (10) tick();
        for (int i = 0; i < nfalls; i++) begin
            dev_clk = 1'b0;
            repeat (20) tick();
            dev_clk = 1'b1;
            if (i < 10) bits[i] = ps2_data_in;
            repeat (20) tick();
        end
    endtask

    // Eleventh clock with optional ACK, then wait (bounded) for tx_done.
    task automatic dev_ack(input bit ack, output int wait_n);
        dev_data = ~ack;
        repeat (3) tick();
        dev_clk = 1'b0;
        repeat (20) tick();
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        wait_n = 0;
        while (!tx_done && wait_n < 100) begin
            tick();
            wait_n++;
        end
    endtask

    initial begin
        logic [9:0] bits;
        int         n;
        int         nd;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) tick();
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_active", 32'(tx_active), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_ack_ok", 32'(tx_ack_ok), 0);
        check("rst_error", 32'(tx_error), 0);
        check("rst_clk_pd", 32'(ps2_clock_pulldown), 0);
        check("rst_dat_pd", 32'(ps2_data_pulldown), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 0xED with ACK: bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
        start_tx(8'hED, 1'b0);
        dev_bits(10, bits);
        check("ed_bits", 32'(bits), 32'h3ED);
        check("ed_ack_state_data_released", 32'(ps2_data_pulldown), 0);
        dev_ack(1'b1, n);
        check("ed_done", 32'(tx_done), 1);
        check("ed_ack_ok", 32'(tx_ack_ok), 1);
        check("ed_error", 32'(tx_error), 0);
        check("ed_ready_at_done", 32'(tx_ready), 1);
        tick();
        check("ed_done_one_cycle", 32'(tx_done), 0);
        check("ed_ack_ok_held", 32'(tx_ack_ok), 1);
        repeat (5) tick();

        // 0x01 with tx_valid held high: parity 0, exactly one frame.
        n_starts = 0;
        mon_en   = 1'b1;
        start_tx(8'h01, 1'b1);
        dev_bits(10, bits);
        check("x01_bits", 32'(bits), 32'h201);
        check("x01_ready_low_in_frame", 32'(tx_ready), 0);
        dev_ack(1'b1, n);
        tx_valid = 1'b0;
        check("x01_done", 32'(tx_done), 1);
        check("x01_ack_ok", 32'(tx_ack_ok), 1);
        repeat (30) tick();
        mon_en = 1'b0;
        check("x01_single_frame", n_starts, 1);
        check("x01_idle_after", 32'(tx_active), 0);

        // 0x3C, device omits ACK.
        start_tx(8'h3C, 1'b0);
        dev_bits(10, bits);
        check("x3c_bits", 32'(bits), 32'h33C);
        dev_ack(1'b0, n);
        check("noack_done", 32'(tx_done), 1);
        check("noack_ack_ok", 32'(tx_ack_ok), 0);
        check("noack_error", 32'(tx_error), 1);
        repeat (5) tick();

        // Device never clocks: timeout 200 cycles after clock release.
        start_tx(8'hA5, 1'b0);
        n = 0;
        while (!tx_done && n < 400) begin
            tick();
            n++;
        end
        check("first_edge_timeout_cycles", n, 200);
        check("first_edge_timeout_error", 32'(tx_error), 1);
        check("first_edge_timeout_ack_ok", 32'(tx_ack_ok), 0);
        check("first_edge_timeout_clk_pd", 32'(ps2_clock_pulldown), 0);
        check("first_edge_timeout_dat_pd", 32'(ps2_data_pulldown), 0);
        repeat (5) tick();

        // Device stops after the 4th fall. Pin edge to detection is 2 sync stages plus the
        // registering edge (3 cycles), then 50 cycles of watchdog.
        start_tx(8'hED, 1'b0);
        dev_bits(3, bits);
        dev_clk = 1'b0;
        n = 0;
        while (!tx_done && n < 200) begin
            tick();
            n++;
            if (n == 20) dev_clk = 1'b1;
        end
        check("edge_timeout_cycles", n, 53);
        check("edge_timeout_error", 32'(tx_error), 1);
        check("edge_timeout_clk_pd", 32'(ps2_clock_pulldown), 0);
        check("edge_timeout_dat_pd", 32'(ps2_data_pulldown), 0);
        repeat (5) tick();

        // Reset during bit 5 of 0x00 (data held low by the host at that point).
        start_tx(8'h00, 1'b0);
        dev_bits(6, bits);
        check("x00_first_bits", 32'(bits[5:0]), 0);
        check("x00_bit5_data_low", 32'(ps2_data_pulldown), 1);
        rst_n = 1'b0;
        tick();
        check("midrst_clk_pd", 32'(ps2_clock_pulldown), 0);
        check("midrst_dat_pd", 32'(ps2_data_pulldown), 0);
        check("midrst_ready", 32'(tx_ready), 1);
        check("midrst_active", 32'(tx_active), 0);
        check("midrst_done", 32'(tx_done), 0);
        check("midrst_error_cleared", 32'(tx_error), 0);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (tx_done) nd++;
        end
        check("midrst_no_done", nd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
